// File: rtl/serial_subtractor.sv
// Bit-serial unsigned a-b, LSB first, one borrow FF; done pulses WIDTH+1 cycles after start.
// start is only honoured in IDLE/DONE (back-to-back OK); start while busy is dropped.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             d;
    logic             br_nxt;
    logic [WIDTH-1:0] res_nxt;
    logic             last;

    // One full-subtractor slice on the current LSBs.
    always_comb begin
        d       = a_sh[0] ^ b_sh[0] ^ br;
        br_nxt  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
        res_nxt = {d, {(WIDTH-1){1'b0}}} | (res_sh >> 1);
        last    = (cnt == CW'(WIDTH-1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            borrow <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state  <= RUN;
                        a_sh   <= a;
                        b_sh   <= b;
                        res_sh <= '0;
                        br     <= 1'b0;
                        cnt    <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    br     <= br_nxt;
                    res_sh <= res_nxt;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        diff   <= res_nxt;
                        borrow <= br_nxt;
                        state  <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor against a plain-arithmetic a-b model.
module tb_serial_subtractor;
    localparam int W   = 8;
    localparam int LAT = W + 1;
    localparam int BOUND = 40;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;

    int tests = 0;
    int fails = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff), .borrow(borrow)
    );

    always #5 clk = ~clk;

    function automatic int model_diff(input int x, input int y);
        return (x - y + (1 << W)) % (1 << W);
    endfunction

    function automatic int model_borrow(input int x, input int y);
        return (x < y) ? 1 : 0;
    endfunction

    // Drive one start pulse and wait for done; reports what was seen.
    task automatic run_op(input int x, input int y, output int rd, output int rb,
                          output int lat, output int busy_cnt, output int done_after);
        @(negedge clk);
        a = x[W-1:0]; b = y[W-1:0]; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        busy_cnt = busy ? 1 : 0;
        while (!done && lat < BOUND) begin
            @(posedge clk); #1;
            lat++;
            if (busy) busy_cnt++;
        end
        rd = int'(diff); rb = int'(borrow);
        @(posedge clk); #1;
        done_after = int'(done);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; a = '0; b = '0;
        #12;
        tests++; if (busy !== 1'b0)   begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (done !== 1'b0)   begin fails++; $display("FAIL reset_done got %b want 0", done); end
        tests++; if (diff !== '0)     begin fails++; $display("FAIL reset_diff got %0d want 0", diff); end
        tests++; if (borrow !== 1'b0) begin fails++; $display("FAIL reset_borrow got %b want 0", borrow); end
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_directed();
        int ta[5] = '{100, 5, 0, 255, 0};
        int tb[5] = '{37, 9, 255, 255, 0};
        int rd, rb, lat, bc, da;
        for (int i = 0; i < 5; i++) begin
            run_op(ta[i], tb[i], rd, rb, lat, bc, da);
            tests++; if (rd != model_diff(ta[i], tb[i])) begin fails++;
                $display("FAIL dir_diff %0d-%0d got %0d want %0d", ta[i], tb[i], rd, model_diff(ta[i], tb[i])); end
            tests++; if (rb != model_borrow(ta[i], tb[i])) begin fails++;
                $display("FAIL dir_borrow %0d-%0d got %0d want %0d", ta[i], tb[i], rb, model_borrow(ta[i], tb[i])); end
            tests++; if (lat != LAT) begin fails++;
                $display("FAIL dir_latency %0d-%0d got %0d want %0d", ta[i], tb[i], lat, LAT); end
            tests++; if (bc != W) begin fails++;
                $display("FAIL dir_busy_cycles got %0d want %0d", bc, W); end
            tests++; if (da != 0) begin fails++;
                $display("FAIL dir_done_width done still %0d one cycle later", da); end
        end
    endtask

    task automatic test_ignored_start();
        int lat = 1;
        @(negedge clk);
        a = 8'd200; b = 8'd100; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1; lat++;
        @(negedge clk); a = 8'd1; b = 8'd2; start = 1'b1;
        @(posedge clk); #1; start = 1'b0; lat++;
        while (!done && lat < BOUND) begin @(posedge clk); #1; lat++; end
        tests++; if (lat != LAT) begin fails++; $display("FAIL ign_latency got %0d want %0d", lat, LAT); end
        tests++; if (diff !== 8'd100) begin fails++; $display("FAIL ign_diff got %0d want 100", diff); end
        tests++; if (borrow !== 1'b0) begin fails++; $display("FAIL ign_borrow got %b want 0", borrow); end
        @(posedge clk); #1;
        tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++;
            $display("FAIL ign_idle busy=%b done=%b want 0/0", busy, done); end
    endtask

    task automatic test_back_to_back();
        int lat = 1;
        int held = 1;
        @(negedge clk);
        a = 8'd50; b = 8'd20; start = 1'b1;
        @(posedge clk); #1;
        a = 8'd7; b = 8'd9;
        while (!done && lat < BOUND) begin @(posedge clk); #1; lat++; end
        tests++; if (lat != LAT) begin fails++; $display("FAIL b2b_lat1 got %0d want %0d", lat, LAT); end
        tests++; if (diff !== 8'd30) begin fails++; $display("FAIL b2b_diff1 got %0d want 30", diff); end
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
            if (!done && diff !== 8'd30) held = 0;
        end while (!done && lat < BOUND);
        start = 1'b0;
        tests++; if (lat != LAT) begin fails++; $display("FAIL b2b_lat2 got %0d want %0d", lat, LAT); end
        tests++; if (held != 1) begin fails++; $display("FAIL b2b_hold diff did not hold 30 between dones"); end
        tests++; if (diff !== 8'd254) begin fails++; $display("FAIL b2b_diff2 got %0d want 254", diff); end
        tests++; if (borrow !== 1'b1) begin fails++; $display("FAIL b2b_borrow2 got %b want 1", borrow); end
        @(posedge clk); #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_idle busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        int rd, rb, lat, bc, da;
        int saw_done = 0;
        @(negedge clk);
        a = 8'd77; b = 8'd11; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        tests++; if (busy !== 1'b0)   begin fails++; $display("FAIL rmid_busy got %b want 0", busy); end
        tests++; if (done !== 1'b0)   begin fails++; $display("FAIL rmid_done got %b want 0", done); end
        tests++; if (diff !== '0)     begin fails++; $display("FAIL rmid_diff got %0d want 0", diff); end
        tests++; if (borrow !== 1'b0) begin fails++; $display("FAIL rmid_borrow got %b want 0", borrow); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (12) begin @(posedge clk); #1; if (done) saw_done = 1; end
        tests++; if (saw_done != 0) begin fails++; $display("FAIL rmid_no_done got done pulse want none"); end
        run_op(10, 3, rd, rb, lat, bc, da);
        tests++; if (rd != 7) begin fails++; $display("FAIL rmid_after_diff got %0d want 7", rd); end
        tests++; if (lat != LAT) begin fails++; $display("FAIL rmid_after_lat got %0d want %0d", lat, LAT); end
    endtask

    task automatic test_random();
        int x, y, rd, rb, lat, bc, da;
        for (int i = 0; i < 1000; i++) begin
            x = int'($urandom_range(0, (1 << W) - 1));
            y = int'($urandom_range(0, (1 << W) - 1));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
            run_op(x, y, rd, rb, lat, bc, da);
            tests++; if (rd != model_diff(x, y)) begin fails++;
                $display("FAIL rnd_diff %0d-%0d got %0d want %0d", x, y, rd, model_diff(x, y)); end
            tests++; if (rb != model_borrow(x, y)) begin fails++;
                $display("FAIL rnd_borrow %0d-%0d got %0d want %0d", x, y, rb, model_borrow(x, y)); end
            tests++; if (lat != LAT) begin fails++;
                $display("FAIL rnd_latency %0d-%0d got %0d want %0d", x, y, lat, LAT); end
            tests++; if (da != 0) begin fails++;
                $display("FAIL rnd_done_width %0d-%0d done stayed high", x, y); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
